// File: rtl/issue_cdb_scheduler.sv
// CDB issue scheduler: grants one issue per unit class per cycle and reserves future
// CDB slots so that the int, ld, mult and div units never drive the bus together.
module issue_cdb_scheduler #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_int,
    input  logic       req_ld,
    input  logic       req_mult,
    input  logic       req_div,
    output logic       grant_int,
    output logic       grant_ld,
    output logic       grant_mult,
    output logic       grant_div,
    output logic [1:0] cdb_sel,
    output logic       cdb_valid,
    output logic       div_busy,
    output logic       div_done
);

    localparam int NSLOT = DIV_LAT - 1;
    // A claim at offset k lands in slot k-1 of the next-cycle reservation.
    localparam int MULT_SLOT = MULT_LAT - 2;
    localparam int DIV_SLOT  = DIV_LAT - 2;
    localparam logic [3:0] DIV_CNT_LOAD = 4'(DIV_LAT - 2);

    typedef enum logic [1:0] {
        SEL_INT  = 2'd0,
        SEL_LD   = 2'd1,
        SEL_MULT = 2'd2,
        SEL_DIV  = 2'd3
    } cdb_owner_t;

    logic [NSLOT-1:0]      res_r, res_next;
    logic [NSLOT-1:0][1:0] own_r, own_next;
    logic [3:0]            div_cnt, div_cnt_next;
    logic                  lru, lru_next;

    assign div_busy = (div_cnt != 4'd0);

    // NOTE: every signal written in an always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_int  = 1'b0;
        grant_ld   = 1'b0;
        grant_div  = req_div & ~div_busy;
        grant_mult = req_mult & ~res_r[MULT_LAT-1];
        if (!res_r[0]) begin
            if (req_int && (!req_ld || !lru)) grant_int = 1'b1;
            else if (req_ld)                  grant_ld  = 1'b1;
        end

        cdb_valid = 1'b0;
        cdb_sel   = SEL_INT;
        if (res_r[0]) begin
            cdb_valid = 1'b1;
            cdb_sel   = own_r[0];
        end else if (grant_int || grant_ld) begin
            cdb_valid = 1'b1;
            cdb_sel   = grant_ld ? SEL_LD : SEL_INT;
        end
        div_done = cdb_valid && (cdb_sel == SEL_DIV);
    end

    always_comb begin
        res_next = {1'b0, res_r[NSLOT-1:1]};
        own_next = {2'b00, own_r[NSLOT-1:1]};
        if (grant_mult) begin
            res_next[MULT_SLOT] = 1'b1;
            own_next[MULT_SLOT] = SEL_MULT;
        end
        if (grant_div) begin
            res_next[DIV_SLOT] = 1'b1;
            own_next[DIV_SLOT] = SEL_DIV;
        end

        div_cnt_next = div_cnt;
        if (grant_div)     div_cnt_next = DIV_CNT_LOAD;
        else if (div_busy) div_cnt_next = div_cnt - 4'd1;

        lru_next = lru;
        if (grant_int)     lru_next = 1'b1;
        else if (grant_ld) lru_next = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_r   <= '0;
            own_r   <= '0;
            div_cnt <= '0;
            lru     <= 1'b0;
        end else begin
            res_r   <= res_next;
            own_r   <= own_next;
            div_cnt <= div_cnt_next;
            lru     <= lru_next;
        end
    end

endmodule

// File: tb/tb_issue_cdb_scheduler.sv
// Directed bench for issue_cdb_scheduler: hand-computed grant/CDB vectors per cycle plus a
// per-cycle scoreboard that predicts CDB ownership from observed grants.
module tb_issue_cdb_scheduler;

    localparam int ML = 4;
    localparam int DL = 7;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] INT  = 4'b1000;
    localparam logic [3:0] LD   = 4'b0100;
    localparam logic [3:0] MUL  = 4'b0010;
    localparam logic [3:0] DIV  = 4'b0001;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_int, req_ld, req_mult, req_div;
    logic       grant_int, grant_ld, grant_mult, grant_div;
    logic [1:0] cdb_sel;
    logic       cdb_valid, div_busy, div_done;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic       slot_v [64];
    logic [1:0] slot_o [64];
    int         cyc = 0;

    issue_cdb_scheduler #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_int   (req_int),
        .req_ld    (req_ld),
        .req_mult  (req_mult),
        .req_div   (req_div),
        .grant_int (grant_int),
        .grant_ld  (grant_ld),
        .grant_mult(grant_mult),
        .grant_div (grant_div),
        .cdb_sel   (cdb_sel),
        .cdb_valid (cdb_valid),
        .div_busy  (div_busy),
        .div_done  (div_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, check outputs mid-cycle, advance to the next cycle.
    task automatic step(input string tag, input logic [3:0] req, input logic [3:0] exp_g,
                        input logic exp_v, input logic [1:0] exp_sel, input logic exp_busy);
        {req_int, req_ld, req_mult, req_div} = req;
        #1;
        check({tag, "/grant"}, {grant_int, grant_ld, grant_mult, grant_div}, exp_g);
        check({tag, "/valid"}, {3'b000, cdb_valid}, {3'b000, exp_v});
        check({tag, "/sel"},   {2'b00, cdb_sel},    {2'b00, exp_sel});
        check({tag, "/busy"},  {3'b000, div_busy},  {3'b000, exp_busy});
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every mult/div grant books its CDB cycle; the bus must match each cycle.
    initial begin
        for (int i = 0; i < 64; i++) begin
            slot_v[i] = 1'b0;
            slot_o[i] = 2'd0;
        end
        forever begin
            @(negedge clk);
            if (mon_en) begin
                int i0;
                i0 = cyc % 64;
                check("mon/int_and_ld", {3'b000, grant_int & grant_ld}, 4'd0);
                if (slot_v[i0]) begin
                    check("mon/slot_valid", {3'b000, cdb_valid}, 4'd1);
                    check("mon/slot_sel", {2'b00, cdb_sel}, {2'b00, slot_o[i0]});
                    check("mon/slot_blocks_int_ld", {3'b000, grant_int | grant_ld}, 4'd0);
                end else if (grant_int || grant_ld) begin
                    check("mon/intld_valid", {3'b000, cdb_valid}, 4'd1);
                    check("mon/intld_sel", {2'b00, cdb_sel}, {3'b000, grant_ld});
                end else begin
                    check("mon/idle_valid", {3'b000, cdb_valid}, 4'd0);
                end
                check("mon/div_done", {3'b000, div_done},
                      {3'b000, slot_v[i0] && (slot_o[i0] == 2'd3)});
                slot_v[i0] = 1'b0;
                if (grant_mult) begin
                    check("mon/mult_slot_free", {3'b000, slot_v[(cyc + ML - 1) % 64]}, 4'd0);
                    slot_v[(cyc + ML - 1) % 64] = 1'b1;
                    slot_o[(cyc + ML - 1) % 64] = 2'd2;
                end
                if (grant_div) begin
                    check("mon/div_slot_free", {3'b000, slot_v[(cyc + DL - 1) % 64]}, 4'd0);
                    slot_v[(cyc + DL - 1) % 64] = 1'b1;
                    slot_o[(cyc + DL - 1) % 64] = 2'd3;
                end
                if (reset) begin
                    for (int i = 0; i < 64; i++) slot_v[i] = 1'b0;
                end
                cyc++;
            end
        end
    end

    initial begin
        reset = 1'b1;
        {req_int, req_ld, req_mult, req_div} = NONE;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        step("reset_state", NONE, NONE, 1'b0, 2'd0, 1'b0);

        // int and ld both ready: strict alternation starting with int
        step("alt_c0", INT | LD, INT, 1'b1, 2'd0, 1'b0);
        step("alt_c1", INT | LD, LD,  1'b1, 2'd1, 1'b0);
        step("alt_c2", INT | LD, INT, 1'b1, 2'd0, 1'b0);
        step("alt_c3", INT | LD, LD,  1'b1, 2'd1, 1'b0);

        // int alone every cycle; lru then prefers ld
        for (int i = 0; i < 4; i++) step("int_only", INT, INT, 1'b1, 2'd0, 1'b0);
        step("lru_after_int", INT | LD, LD, 1'b1, 2'd1, 1'b0);
        step("ld_only", LD, LD, 1'b1, 2'd1, 1'b0);
        step("lru_after_ld", INT | LD, INT, 1'b1, 2'd0, 1'b0);

        // mult pulse with int held: mult owns the bus three cycles later
        step("mul_c0", INT | MUL, INT | MUL, 1'b1, 2'd0, 1'b0);
        step("mul_c1", INT, INT, 1'b1, 2'd0, 1'b0);
        step("mul_c2", INT, INT, 1'b1, 2'd0, 1'b0);
        step("mul_c3", INT, NONE, 1'b1, 2'd2, 1'b0);
        step("mul_c4", INT, INT, 1'b1, 2'd0, 1'b0);
        step("mul_idle", NONE, NONE, 1'b0, 2'd0, 1'b0);

        // div held with int: grants at c0, c6, c12; int denied on div result cycles
        step("div_c0", INT | DIV, INT | DIV, 1'b1, 2'd0, 1'b0);
        for (int i = 1; i <= 5; i++) step("div_busy1", INT | DIV, INT, 1'b1, 2'd0, 1'b1);
        step("div_c6", INT | DIV, DIV, 1'b1, 2'd3, 1'b0);
        for (int i = 7; i <= 11; i++) step("div_busy2", INT | DIV, INT, 1'b1, 2'd0, 1'b1);
        step("div_c12", INT | DIV, DIV, 1'b1, 2'd3, 1'b0);
        for (int i = 13; i <= 17; i++) step("div_busy3", NONE, NONE, 1'b0, 2'd0, 1'b1);
        step("div_c18", NONE, NONE, 1'b1, 2'd3, 1'b0);
        step("div_idle", NONE, NONE, 1'b0, 2'd0, 1'b0);

        // mult colliding with an in-flight div result slot is deferred one cycle
        step("dm_c0", DIV, DIV, 1'b0, 2'd0, 1'b0);
        step("dm_c1", NONE, NONE, 1'b0, 2'd0, 1'b1);
        step("dm_c2", NONE, NONE, 1'b0, 2'd0, 1'b1);
        step("dm_c3_deny", MUL, NONE, 1'b0, 2'd0, 1'b1);
        step("dm_c4_grant", MUL, MUL, 1'b0, 2'd0, 1'b1);
        step("dm_c5", NONE, NONE, 1'b0, 2'd0, 1'b1);
        step("dm_c6", NONE, NONE, 1'b1, 2'd3, 1'b0);
        step("dm_c7", NONE, NONE, 1'b1, 2'd2, 1'b0);
        step("dm_c8", NONE, NONE, 1'b0, 2'd0, 1'b0);

        // reset with mult and div in flight abandons both reservations
        step("rs_c0", MUL | DIV, MUL | DIV, 1'b0, 2'd0, 1'b0);
        step("rs_c1", NONE, NONE, 1'b0, 2'd0, 1'b1);
        reset = 1'b1;
        step("rs_c2", NONE, NONE, 1'b0, 2'd0, 1'b1);
        reset = 1'b0;
        step("rs_c3", NONE, NONE, 1'b0, 2'd0, 1'b0);
        for (int i = 4; i <= 9; i++) step("rs_after", NONE, NONE, 1'b0, 2'd0, 1'b0);
        step("rs_int_ok", INT | LD, INT, 1'b1, 2'd0, 1'b0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
